// File: rtl/intblock_arb_pkg.sv
// Shared types and helpers for the integer-block issue arbiter.
// Holds the ROB-id age compare used by both the arbiter and its age selector.
package intblock_arb_pkg;

   localparam int unsigned DEF_ROBID_W   = 7;
   localparam int unsigned DEF_PAYLOAD_W = 256;
   localparam int unsigned ROBID_MAX_W   = 16;

   typedef struct packed {
      logic [DEF_ROBID_W-1:0]   robid;
      logic [DEF_PAYLOAD_W-1:0] payload;
   } req_bundle_t;

   // a is older than b; w is the live id width, MSB of that width is the wrap bit.
   function automatic logic robid_older(input logic [ROBID_MAX_W-1:0] a,
                                        input logic [ROBID_MAX_W-1:0] b,
                                        input int unsigned            w);
      logic [ROBID_MAX_W-1:0] wrap_bit;
      logic [ROBID_MAX_W-1:0] idx_mask;
      wrap_bit = ROBID_MAX_W'(1) << (w - 1);
      idx_mask = wrap_bit - ROBID_MAX_W'(1);
      return (|((a ^ b) & wrap_bit)) ^ ((a & idx_mask) < (b & idx_mask));
   endfunction

endpackage

// File: rtl/intblock_age_sel.sv
// Combinational oldest-of-N select by ROB id; equal ages resolve to the lowest index.
module intblock_age_sel
   import intblock_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ROBID_W = DEF_ROBID_W
) (
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [NUM_REQ*ROBID_W-1:0] robid,
   output logic [NUM_REQ-1:0]         sel,
   output logic                       sel_valid
);

   logic [ROBID_W-1:0] best;

   // Strictly-older replacement keeps the lower index on a tie.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      best      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (valid[i] && (!sel_valid ||
             robid_older(ROBID_MAX_W'(robid[i*ROBID_W +: ROBID_W]),
                         ROBID_MAX_W'(best), ROBID_W))) begin
            sel       = '0;
            sel[i]    = 1'b1;
            sel_valid = 1'b1;
            best      = robid[i*ROBID_W +: ROBID_W];
         end
      end
   end

endmodule

// File: rtl/intblock_issue_arb.sv
// Issue arbiter for the shared ALU/BJU/MULDIV block: oldest-first with a starvation guard.
// Optional performance counters are enabled with `define INTBLOCK_ARB_PMU_EN.
module intblock_issue_arb
   import intblock_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = 2,
   parameter  int unsigned ROBID_W      = DEF_ROBID_W,
   parameter  int unsigned PAYLOAD_W    = DEF_PAYLOAD_W,
   parameter  int unsigned STARVE_LIMIT = 8,
   localparam int unsigned SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ROBID_W-1:0]     req_robid,
   input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ROBID_W-1:0]             out_robid,
   output logic [PAYLOAD_W-1:0]           out_payload,
   output logic [SRC_W-1:0]               out_src,
   input  logic                           flush_valid,
   input  logic [ROBID_W-1:0]             flush_robid
`ifdef INTBLOCK_ARB_PMU_EN
   ,
   output logic [NUM_REQ*32-1:0]          arb_pmu_grant_cnt,
   output logic [31:0]                    arb_pmu_starve_cnt,
   output logic [31:0]                    arb_pmu_stall_cnt,
   output logic [31:0]                    arb_pmu_kill_cnt
`endif
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]           cnt_q [NUM_REQ];
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   starved;
   logic [NUM_REQ-1:0]   age_pick;
   logic                 age_valid;
   logic [NUM_REQ-1:0]   grant;
   logic                 forced;
   logic                 kill_out;
   logic                 slot_free;
   logic [ROBID_W-1:0]   win_robid;
   logic [PAYLOAD_W-1:0] win_payload;
   logic [SRC_W-1:0]     win_src;

   always_comb begin
      kill_out  = flush_valid && robid_older(ROBID_MAX_W'(flush_robid),
                                             ROBID_MAX_W'(out_robid), ROBID_W);
      slot_free = !out_valid || out_ready || kill_out;
      eligible  = '0;
      starved   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] &&
                       !(flush_valid && robid_older(ROBID_MAX_W'(flush_robid),
                         ROBID_MAX_W'(req_robid[i*ROBID_W +: ROBID_W]), ROBID_W));
         starved[i]  = eligible[i] && (cnt_q[i] == LIMIT);
      end
   end

   intblock_age_sel #(
      .NUM_REQ (NUM_REQ),
      .ROBID_W (ROBID_W)
   ) u_age_sel (
      .valid     (eligible),
      .robid     (req_robid),
      .sel       (age_pick),
      .sel_valid (age_valid)
   );

   // Starved requesters pre-empt the age order, lowest index first.
   always_comb begin
      grant  = '0;
      forced = 1'b0;
      if (!reset && slot_free) begin
         if (|starved) begin
            forced = 1'b1;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
               if (starved[i]) begin
                  grant    = '0;
                  grant[i] = 1'b1;
               end
            end
         end else if (age_valid) begin
            grant = age_pick;
         end
      end
   end

   assign req_ready = grant;

   always_comb begin
      win_robid   = '0;
      win_payload = '0;
      win_src     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_robid   = req_robid[i*ROBID_W +: ROBID_W];
            win_payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            win_src     = SRC_W'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_robid   <= '0;
         out_payload <= '0;
         out_src     <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         if (|grant) begin
            out_valid   <= 1'b1;
            out_robid   <= win_robid;
            out_payload <= win_payload;
            out_src     <= win_src;
         end else if (out_ready || kill_out) begin
            out_valid <= 1'b0;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] || !eligible[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] != LIMIT) begin
               cnt_q[i] <= cnt_q[i] + 4'd1;
            end
         end
      end
   end

`ifdef INTBLOCK_ARB_PMU_EN
   logic [31:0] grant_cnt_q [NUM_REQ];
   logic [31:0] starve_cnt_q;
   logic [31:0] stall_cnt_q;
   logic [31:0] kill_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
         starve_cnt_q <= '0;
         stall_cnt_q  <= '0;
         kill_cnt_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
         end
         if (forced) starve_cnt_q <= starve_cnt_q + 32'd1;
         if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (out_valid && kill_out) kill_cnt_q <= kill_cnt_q + 32'd1;
      end
   end

   always_comb begin
      arb_pmu_grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) arb_pmu_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
   end

   assign arb_pmu_starve_cnt = starve_cnt_q;
   assign arb_pmu_stall_cnt  = stall_cnt_q;
   assign arb_pmu_kill_cnt   = kill_cnt_q;
`endif

endmodule

// File: tb/tb_intblock_issue_arb.sv
// Self-checking bench for intblock_issue_arb: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_intblock_issue_arb;
   import intblock_arb_pkg::*;

   localparam int LIM = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [13:0]  req_robid;
   logic [511:0] req_payload;
   logic         out_valid;
   logic         out_ready;
   logic [6:0]   out_robid;
   logic [255:0] out_payload;
   logic [0:0]   out_src;
   logic         flush_valid;
   logic [6:0]   flush_robid;
`ifdef INTBLOCK_ARB_PMU_EN
   logic [63:0]  arb_pmu_grant_cnt;
   logic [31:0]  arb_pmu_starve_cnt;
   logic [31:0]  arb_pmu_stall_cnt;
   logic [31:0]  arb_pmu_kill_cnt;
`endif

   req_bundle_t rq [2];
   assign req_robid   = {rq[1].robid, rq[0].robid};
   assign req_payload = {rq[1].payload, rq[0].payload};

   always #5 clock = ~clock;

   intblock_issue_arb #(
      .NUM_REQ      (2),
      .ROBID_W      (7),
      .PAYLOAD_W    (256),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_robid   (req_robid),
      .req_payload (req_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_robid   (out_robid),
      .out_payload (out_payload),
      .out_src     (out_src),
      .flush_valid (flush_valid),
      .flush_robid (flush_robid)
`ifdef INTBLOCK_ARB_PMU_EN
      ,
      .arb_pmu_grant_cnt  (arb_pmu_grant_cnt),
      .arb_pmu_starve_cnt (arb_pmu_starve_cnt),
      .arb_pmu_stall_cnt  (arb_pmu_stall_cnt),
      .arb_pmu_kill_cnt   (arb_pmu_kill_cnt)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit           m_valid = 1'b0;
   logic [6:0]   m_robid = '0;
   logic [255:0] m_payload = '0;
   int           m_src = 0;
   int           m_cnt [2] = '{0, 0};
   int           m_gcnt [2] = '{0, 0};
   bit           m_elig [2];
   bit           m_kill_out;
   int           exp_grant;
   logic [1:0]   exp_ready;

   function automatic bit older(input logic [6:0] a, input logic [6:0] b);
      return (a[6] ^ b[6]) ^ (a[5:0] < b[5:0]);
   endfunction

   function automatic logic [255:0] rand_pay();
      logic [255:0] p;
      for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom();
      return p;
   endfunction

   // Winner = first starved eligible; else the eligible one no other eligible beats.
   task automatic model_eval();
      bit free;
      bit wins;
      m_kill_out = flush_valid && older(flush_robid, m_robid);
      free = !m_valid || out_ready || m_kill_out;
      for (int i = 0; i < 2; i++)
         m_elig[i] = req_valid[i] && !(flush_valid && older(flush_robid, rq[i].robid));
      exp_grant = -1;
      if (!reset && free) begin
         for (int i = 0; i < 2; i++)
            if (exp_grant < 0 && m_elig[i] && m_cnt[i] >= LIM) exp_grant = i;
         for (int i = 0; i < 2; i++) begin
            wins = m_elig[i];
            for (int j = 0; j < 2; j++)
               if (j != i && m_elig[j] && (older(rq[j].robid, rq[i].robid) ||
                   (j < i && rq[j].robid == rq[i].robid))) wins = 1'b0;
            if (exp_grant < 0 && wins) exp_grant = i;
         end
      end
      exp_ready = '0;
      if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
   endtask

   task automatic model_commit();
      model_eval();
      if (reset) begin
         m_valid = 0; m_robid = '0; m_payload = '0; m_src = 0;
         m_cnt = '{0, 0}; m_gcnt = '{0, 0};
      end else begin
         if (exp_grant >= 0) begin
            m_valid   = 1;
            m_robid   = rq[exp_grant].robid;
            m_payload = rq[exp_grant].payload;
            m_src     = exp_grant;
            m_gcnt[exp_grant]++;
         end else if (out_ready || m_kill_out) begin
            m_valid = 0;
         end
         for (int i = 0; i < 2; i++) begin
            if (i == exp_grant || !m_elig[i]) m_cnt[i] = 0;
            else if (m_cnt[i] < LIM) m_cnt[i]++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_commit();
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0; out_ready = 1'b1; flush_valid = 1'b0; flush_robid = '0;
      rq[0] = '0; rq[1] = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      req_valid = 2'b11; rq[0].robid = 7'h05; rq[1].robid = 7'h03;
      #3;
      n_total++;
      if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready);
      else n_pass++;
      tick(); tick();
      n_total++;
      if ({out_valid, out_robid, out_src} !== '0 || out_payload !== '0)
         $display("FAIL reset_out: valid=%b robid=%h src=%b", out_valid, out_robid, out_src);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_oldest();
      apply_reset();
      req_valid = 2'b11;
      rq[0] = '{7'h05, rand_pay()}; rq[1] = '{7'h03, rand_pay()};
      #2;
      n_total++;
      if (req_ready !== 2'b10) $display("FAIL oldest_ready: got %b want 10", req_ready);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_robid !== 7'h03 || out_src !== 1'b1 ||
          out_payload !== rq[1].payload)
         $display("FAIL oldest_out: valid=%b robid=%h src=%b want 1/03/1",
                  out_valid, out_robid, out_src);
      else n_pass++;
   endtask

   task automatic test_wrap();
      apply_reset();
      req_valid = 2'b11;
      rq[0] = '{7'h7E, rand_pay()}; rq[1] = '{7'h01, rand_pay()};
      #2;
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL wrap_ready: got %b want 01", req_ready);
      else n_pass++;
      tick();
      req_valid = 2'b10;
      #2;
      n_total++;
      if (out_robid !== 7'h7E || out_src !== 1'b0 || req_ready !== 2'b10)
         $display("FAIL wrap_order: robid=%h src=%b ready=%b want 7e/0/10",
                  out_robid, out_src, req_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_stall();
      logic [255:0] held;
      apply_reset();
      req_valid = 2'b11;
      rq[0] = '{7'h08, rand_pay()}; rq[1] = '{7'h09, rand_pay()};
      held = rq[0].payload;
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_total++;
         if (req_ready !== 2'b00) $display("FAIL stall_ready: cyc %0d got %b want 00",
                                           c, req_ready);
         else n_pass++;
         tick();
         n_total++;
         if (out_valid !== 1'b1 || out_robid !== 7'h08 || out_payload !== held)
            $display("FAIL stall_hold: cyc %0d valid=%b robid=%h want 1/08", c, out_valid,
                     out_robid);
         else n_pass++;
      end
      out_ready = 1'b1;
      #2;
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL stall_release: got %b want 01", req_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      apply_reset();
      req_valid = 2'b01;
      rq[0] = '{7'h10, rand_pay()};
      tick();
      out_ready = 1'b0; rq[0].robid = 7'h20;
      flush_valid = 1'b1; flush_robid = 7'h0C;
      #2;
      n_total++;
      if (req_ready !== 2'b00) $display("FAIL flush_req: got %b want 00", req_ready);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flush_kill: out_valid=%b want 0", out_valid);
      else n_pass++;
      flush_valid = 1'b0; out_ready = 1'b1; rq[0].robid = 7'h10;
      tick();
      out_ready = 1'b0; flush_valid = 1'b1; flush_robid = 7'h10;
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_robid !== 7'h10)
         $display("FAIL flush_equal: valid=%b robid=%h want 1/10", out_valid, out_robid);
      else n_pass++;
      flush_valid = 1'b0;
   endtask

   task automatic run_starve(input string tag);
      out_ready = 1'b1; req_valid = 2'b11;
      rq[1] = '{7'h40, rand_pay()};
      for (int c = 1; c <= 10; c++) begin
         rq[0] = '{7'(c), rand_pay()};
         #2;
         n_total++;
         if (req_ready !== ((c == 9) ? 2'b10 : 2'b01))
            $display("FAIL %s_ready: cyc %0d got %b want %b", tag, c, req_ready,
                     (c == 9) ? 2'b10 : 2'b01);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_starve();
      apply_reset();
      run_starve("starve");
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      req_valid = 2'b11;
      rq[0] = '{7'h02, rand_pay()}; rq[1] = '{7'h03, rand_pay()};
      tick();
      out_ready = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      #2;
      n_total++;
      if (req_ready !== 2'b00) $display("FAIL rst_stall_ready: got %b want 00", req_ready);
      else n_pass++;
      tick();
      n_total++;
      if ({out_valid, out_robid, out_src} !== '0 || out_payload !== '0)
         $display("FAIL rst_stall_out: valid=%b robid=%h src=%b want 0", out_valid,
                  out_robid, out_src);
      else n_pass++;
      reset = 1'b0;
      run_starve("rst_cnt");
`ifdef INTBLOCK_ARB_PMU_EN
      n_total++;
      if (arb_pmu_grant_cnt[31:0] !== 32'(m_gcnt[0]) ||
          arb_pmu_grant_cnt[63:32] !== 32'(m_gcnt[1]))
         $display("FAIL pmu_grant: got %0d/%0d want %0d/%0d", arb_pmu_grant_cnt[31:0],
                  arb_pmu_grant_cnt[63:32], m_gcnt[0], m_gcnt[1]);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      logic [6:0] base;
      apply_reset();
      base = 7'h00;
      for (int c = 0; c < 400; c++) begin
         base = base + 7'(($urandom % 3));
         req_valid   = 2'($urandom);
         rq[0]       = '{base + 7'($urandom_range(0, 15)), rand_pay()};
         rq[1]       = '{base + 7'($urandom_range(0, 15)), rand_pay()};
         out_ready   = ($urandom % 4) != 0;
         flush_valid = ($urandom % 8) == 0;
         flush_robid = base + 7'($urandom_range(0, 15));
         #2;
         model_eval();
         n_total++;
         if (req_ready !== exp_ready || $countones(req_ready) > 1)
            $display("FAIL rand_ready: cyc %0d got %b want %b", c, req_ready, exp_ready);
         else n_pass++;
         tick();
         n_total++;
         if (out_valid !== m_valid ||
             (m_valid && (out_robid !== m_robid || out_src !== m_src[0] ||
                          out_payload !== m_payload)))
            $display("FAIL rand_out: cyc %0d valid=%b robid=%h src=%b want %b/%h/%0d",
                     c, out_valid, out_robid, out_src, m_valid, m_robid, m_src);
         else n_pass++;
      end
      flush_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_oldest();
      test_wrap();
      test_stall();
      test_flush();
      test_starve();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
